// File: rtl/dpram_be_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : dpram_be_pipe_if
// Description : Write/read port bundle for dpram_be_pipe.
// Revision    : 1.0
// ============================================================================
interface dpram_be_pipe_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8
);
    localparam int c_nb = DATA_WIDTH / BYTE_WIDTH;

    logic                  we;
    logic [c_nb-1:0]       be;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] d;
    logic                  re;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic                  busy;

    modport master (
        output we, be, w_addr, d, re, r_addr,
        input  q, q_valid, busy
    );

    modport slave (
        input  we, be, w_addr, d, re, r_addr,
        output q, q_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/dpram_be_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dpram_be_pipe
// Description : Simple dual-port RAM with byte-lane writes, 1/2-cycle read
//               latency, read-during-write mode and post-reset clear.
// Revision    : 1.0
// ============================================================================
module dpram_be_pipe #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int BYTE_WIDTH     = 8,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic           clk,
    input  logic           reset,
    dpram_be_pipe_if.slave bus
);
    localparam int c_nb    = DATA_WIDTH / BYTE_WIDTH;
    localparam int c_depth = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_chk_lanes
        $error("dpram_be_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_chk_latency
        $error("dpram_be_pipe: RD_LATENCY must be 1 or 2");
    end

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_busy;
    logic                  w_clr_wr;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;

    logic                  w_usr_wr;
    logic                  w_usr_rd;
    logic [c_nb-1:0]       w_mem_be;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_din;
    logic [DATA_WIDTH-1:0] w_rd_data;

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_clr_wr    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_busy   = 1'b1;
                w_clr_wr = 1'b1;
                if (r_clr_cnt == c_last_addr) begin
                    w_state_nxt = S_READY;
                end
            end
            default: begin
                w_state_nxt = S_READY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_cnt <= '0;
        end else if (w_clr_wr) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // User traffic is only honoured outside reset and outside the clear sweep.
    assign w_usr_wr = !reset && !w_busy && bus.we;
    assign w_usr_rd = !reset && !w_busy && bus.re;

    always_comb begin
        w_mem_be   = '0;
        w_mem_addr = bus.w_addr;
        w_mem_din  = bus.d;
        if (!reset && w_clr_wr) begin
            w_mem_be   = '1;
            w_mem_addr = r_clr_cnt;
            w_mem_din  = '0;
        end else if (w_usr_wr) begin
            w_mem_be = bus.be;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_nb; i++) begin
            if (w_mem_be[i]) begin
                r_mem[w_mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_mem_din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // New-data mode forwards only the lanes being written this edge.
    always_comb begin
        w_rd_data = r_mem[bus.r_addr];
        if (RDW_MODE != 0 && w_usr_wr && (bus.w_addr == bus.r_addr)) begin
            for (int i = 0; i < c_nb; i++) begin
                if (bus.be[i]) begin
                    w_rd_data[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.d[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_usr_rd;
            if (w_usr_rd) begin
                r_s1_data <= w_rd_data;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  r_s2_valid;
        logic [DATA_WIDTH-1:0] r_s2_data;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_s2_valid <= 1'b0;
                r_s2_data  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign bus.q       = r_s2_data;
        assign bus.q_valid = r_s2_valid;
    end else begin : g_lat1
        assign bus.q       = r_s1_data;
        assign bus.q_valid = r_s1_valid;
    end

    assign bus.busy = w_busy;
endmodule
`default_nettype wire
